halfduplex_responder: RTL and testbench
=======================================

Name: halfduplex_responder

Overview:
Responder end of a single-wire, half-duplex, common-clock link carried on one tristated inout pin. It receives a request word that the initiator serialises onto the shared line. It then releases the line for a turnaround gap, drives back a response word supplied by local logic, and releases the line again. The block sits directly at the pad-level inout, alongside the existing IO buffering logic.

Parameters:
DATA_W, 8, request/response word width in bits
TA_CYCLES, 2, turnaround cycles with the line released between the request's last bit and the response start bit (legal range 1..15)

Ports:
clk  input  1  system clock; the initiator shares this clock
rst  input  1  synchronous, active-high reset
sdio  inout  1  shared serial line; idles high via an external pull-up; driven only while drive_en=1, otherwise 1'bz
drive_en  output  1  registered; 1 while the responder owns sdio
req_valid  output  1  one-cycle pulse; req_data is valid
req_data  output  DATA_W  last received request word; holds until the next request
rsp_valid  input  1  local logic offers a response word
rsp_data  input  DATA_W  response word, sampled when accepted
rsp_ready  output  1  high in cycles where rsp_valid is accepted
timeout  output  1  one-cycle pulse; no response was accepted in the window
busy  output  1  state != IDLE

Behaviour:
- Reset (sampled at clk edge): state=IDLE, drive_en=0 so sdio=z, req_valid=0, req_data=0, rsp_ready=0, timeout=0, all counters 0.
- Reset mid-frame: the line is released on that same edge and no pulses are produced. The next frame is recognised only from IDLE.
- Line format: one bit per clk. Start bit 0, then DATA_W bits LSB first (plus a parity bit if enabled). The responder frame adds a stop bit 1.
- IDLE: sample sdio each cycle; sdio==0 -> RX_DATA with bit count 0.
- RX_DATA: shift in DATA_W bits, one per cycle. After the last bit -> TURN. On the next edge req_valid=1 and req_data is updated. Latency: req_valid is high 1 cycle after the last request bit is on the line.
- TURN: line released for TA_CYCLES cycles.
  - rsp_ready=1 from the req_valid cycle through the last TURN cycle.
  - The first cycle with rsp_valid&rsp_ready captures rsp_data; rsp_ready then drops.
  - rsp_valid in the same cycle as req_valid is accepted.
  - sdio activity during TURN is ignored.
- End of TURN:
  - Response captured -> TX_START.
  - Nothing captured -> timeout pulse for 1 cycle, then -> IDLE with the line still released.
- TX_START: drive_en=1, sdio=0, for 1 cycle.
- TX_DATA: drive DATA_W bits LSB first, 1 per cycle.
- TX_STOP: drive 1 for 1 cycle, then drive_en=0 on the next edge -> IDLE.
- The responder never samples sdio while drive_en=1.
- rsp_valid outside the acceptance window is ignored; rsp_ready=0 there.
- Total frame, no parity: 1+DATA_W request cycles, TA_CYCLES released, 2+DATA_W driven.
- sdio and drive_en are driven from registers only, with no combinational path from inputs.

Optional Feature:
HDX_PARITY_EN
- Defined: an even-parity bit follows the data in both directions.
  - RX_PAR state checks the received parity. On mismatch: no req_valid; perr output pulses 1 cycle; the block skips TURN and returns to IDLE with the line released.
  - TX_PAR state drives the even parity of the captured rsp_data before the stop bit.
- Undefined: no parity bits, no perr port, frame lengths as above.

Decomposition:
- Package hdx_pkg holds:
  - state enum (IDLE, RX_DATA, RX_PAR, TURN, TX_START, TX_DATA, TX_PAR, TX_STOP)
  - default DATA_W and TA_CYCLES constants
  - a bit-count width function
- One natural sub-module: hdx_pad. It holds the registered drive_en/tx_bit flops and the tristate assign for sdio, and returns the sampled line value to the FSM.

Test Plan:
- Request 0xA5 (start, bits 1,0,1,0,0,1,0,1); rsp_valid=1 with 0x3C on the req_valid cycle -> req_valid pulse with req_data=0xA5, exactly 2 released cycles, then sdio=0,0,0,1,1,1,1,0,0,1 and release.
- Request 0x01; rsp_valid asserted on the last TURN cycle with 0xFF -> accepted, response frame 0,1x8,1.
- Request 0x55; rsp_valid never asserted -> timeout pulse 1 cycle after TURN ends, drive_en stays 0, next request 0x66 received normally.
- rst asserted during TX_DATA bit 3 -> drive_en=0 and sdio=z on that edge, busy=0, no further pulses.
- Line held low during TURN and rsp_valid asserted in IDLE -> no false frame, rsp_ready=0, no response driven.
- HDX_PARITY_EN: request 0x07 with parity bit 0 (wrong; correct is 1) -> perr pulse, no req_valid, line never driven. Correct parity with response 0x03 -> TX_PAR drives 0.

Source files
------------

// File: rtl/hdx_pkg.sv
// hdx_pkg: shared states, default sizes and counter-width helper for halfduplex_responder
package hdx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_DATA,
        RX_PAR,
        TURN,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } hdx_state_e;

    localparam int HDX_DATA_W    = 8;
    localparam int HDX_TA_CYCLES = 2;

    // bits needed to count 0..n-1, never less than one
    function automatic int hdx_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hdx_pad.sv
// hdx_pad: registered tristate driver for the shared sdio line, returns the line value
module hdx_pad (
    input  logic clk,
    input  logic rst,
    input  logic drive_en_d,
    input  logic tx_bit_d,
    output logic drive_en,
    output logic rx_bit,
    inout  wire  sdio
);

    logic drive_en_q;
    logic tx_bit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drive_en_q <= 1'b0;
            tx_bit_q   <= 1'b1;
        end else begin
            drive_en_q <= drive_en_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    assign sdio     = drive_en_q ? tx_bit_q : 1'bz;
    assign drive_en = drive_en_q;
    assign rx_bit   = sdio;

endmodule

// File: rtl/halfduplex_responder.sv
// halfduplex_responder: responder end of a single-wire half-duplex serial link
// Optional even parity in both directions when HDX_PARITY_EN is defined (adds perr port).
module halfduplex_responder
    import hdx_pkg::*;
#(
    parameter int DATA_W    = HDX_DATA_W,
    parameter int TA_CYCLES = HDX_TA_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire               sdio,
    output logic              drive_en,
    output logic              req_valid,
    output logic [DATA_W-1:0] req_data,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ready,
    output logic              timeout,
`ifdef HDX_PARITY_EN
    output logic              perr,
`endif
    output logic              busy
);

    localparam int BW = hdx_cnt_w(DATA_W);
    localparam int TW = hdx_cnt_w(TA_CYCLES);

    hdx_state_e        state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [TW-1:0]     ta_q, ta_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              got_q, got_d;
    logic              req_valid_q, req_valid_d;
    logic              rsp_ready_q, rsp_ready_d;
    logic              timeout_q, timeout_d;
`ifdef HDX_PARITY_EN
    logic              perr_q, perr_d;
    logic              par_q, par_d;
`endif
    logic              drive_en_d, tx_bit_d, rx_bit, accept;

    hdx_pad u_pad (
        .clk        (clk),
        .rst        (rst),
        .drive_en_d (drive_en_d),
        .tx_bit_d   (tx_bit_d),
        .drive_en   (drive_en),
        .rx_bit     (rx_bit),
        .sdio       (sdio)
    );

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        ta_d        = ta_q;
        sh_d        = sh_q;
        rsp_d       = rsp_q;
        got_d       = got_q;
        req_data_d  = req_data_q;
        rsp_ready_d = rsp_ready_q;
        req_valid_d = 1'b0;
        timeout_d   = 1'b0;
`ifdef HDX_PARITY_EN
        perr_d      = 1'b0;
        par_d       = par_q;
`endif
        drive_en_d  = drive_en;
        tx_bit_d    = 1'b1;
        accept      = rsp_valid & rsp_ready_q;
        case (state_q)
            IDLE: begin
                if (!rx_bit) begin
                    state_d = RX_DATA;
                    bit_d   = '0;
                end
            end
            RX_DATA: begin
                sh_d  = {rx_bit, sh_q[DATA_W-1:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(DATA_W - 1)) begin
`ifdef HDX_PARITY_EN
                    state_d = RX_PAR;
`else
                    state_d     = TURN;
                    req_valid_d = 1'b1;
                    req_data_d  = sh_d;
                    rsp_ready_d = 1'b1;
                    ta_d        = '0;
                    got_d       = 1'b0;
`endif
                end
            end
`ifdef HDX_PARITY_EN
            RX_PAR: begin
                if (^{sh_q, rx_bit}) begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d     = TURN;
                    req_valid_d = 1'b1;
                    req_data_d  = sh_q;
                    rsp_ready_d = 1'b1;
                    ta_d        = '0;
                    got_d       = 1'b0;
                end
            end
`endif
            TURN: begin
                if (accept) begin
                    rsp_d       = rsp_data;
                    got_d       = 1'b1;
                    rsp_ready_d = 1'b0;
`ifdef HDX_PARITY_EN
                    par_d       = ^rsp_data;
`endif
                end
                if (ta_q == TW'(TA_CYCLES - 1)) begin
                    rsp_ready_d = 1'b0;
                    if (got_q | accept) begin
                        state_d    = TX_START;
                        drive_en_d = 1'b1;
                        tx_bit_d   = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end else begin
                    ta_d = ta_q + 1'b1;
                end
            end
            TX_START: begin
                state_d  = TX_DATA;
                bit_d    = '0;
                tx_bit_d = rsp_q[0];
                rsp_d    = rsp_q >> 1;
            end
            TX_DATA: begin
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(DATA_W - 1)) begin
`ifdef HDX_PARITY_EN
                    state_d  = TX_PAR;
                    tx_bit_d = par_q;
`else
                    state_d  = TX_STOP;
`endif
                end else begin
                    tx_bit_d = rsp_q[0];
                    rsp_d    = rsp_q >> 1;
                end
            end
            TX_STOP: begin
                state_d    = IDLE;
                drive_en_d = 1'b0;
            end
            default: begin
                // TX_PAR lands here too: its stop bit is the default tx_bit_d
                state_d = (state_q == TX_PAR) ? TX_STOP : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            ta_q        <= '0;
            sh_q        <= '0;
            rsp_q       <= '0;
            got_q       <= 1'b0;
            req_data_q  <= '0;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef HDX_PARITY_EN
            perr_q      <= 1'b0;
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            ta_q        <= ta_d;
            sh_q        <= sh_d;
            rsp_q       <= rsp_d;
            got_q       <= got_d;
            req_data_q  <= req_data_d;
            req_valid_q <= req_valid_d;
            rsp_ready_q <= rsp_ready_d;
            timeout_q   <= timeout_d;
`ifdef HDX_PARITY_EN
            perr_q      <= perr_d;
            par_q       <= par_d;
`endif
        end
    end

    assign req_valid = req_valid_q;
    assign req_data  = req_data_q;
    assign rsp_ready = rsp_ready_q;
    assign timeout   = timeout_q;
`ifdef HDX_PARITY_EN
    assign perr      = perr_q;
`endif
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_halfduplex_responder.sv
// tb_halfduplex_responder: scoreboard bench for halfduplex_responder
// Parity scenarios are compiled in when HDX_PARITY_EN is defined.
module tb_halfduplex_responder;

    localparam int DATA_W    = 8;
    localparam int TA_CYCLES = 2;
`ifdef HDX_PARITY_EN
    localparam int FW = DATA_W + 3;
`else
    localparam int FW = DATA_W + 2;
`endif
    localparam logic [7:0] EV_REQ = 8'd1;
    localparam logic [7:0] EV_TO  = 8'd2;
    localparam logic [7:0] EV_FR  = 8'd3;
    localparam logic [7:0] EV_PE  = 8'd4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tb_en = 1'b0;
    logic              tb_bit = 1'b1;
    logic              drive_en, req_valid, rsp_valid, rsp_ready, timeout, busy;
    logic [DATA_W-1:0] req_data, rsp_data;
`ifdef HDX_PARITY_EN
    logic              perr;
`endif
    wire               sdio;

    pullup (sdio);
    assign sdio = tb_en ? tb_bit : 1'bz;

    halfduplex_responder #(.DATA_W(DATA_W), .TA_CYCLES(TA_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .sdio      (sdio),
        .drive_en  (drive_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .timeout   (timeout),
`ifdef HDX_PARITY_EN
        .perr      (perr),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ev(input logic [7:0] kind, input logic [23:0] data);
        return {kind, data};
    endfunction

    function automatic logic [23:0] frame_of(input logic [DATA_W-1:0] d);
`ifdef HDX_PARITY_EN
        return {13'b0, 1'b1, ^d, d, 1'b0};
`else
        return {14'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [31:0] act);
        logic [31:0] e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got unexpected event %0h, expected none", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
                n_fail++;
                $display("FAIL %s: got %0h, expected %0h", name, act, e);
            end
        end
    endtask

    // monitor: every DUT output event is matched against the scoreboard queue
    logic        collecting = 1'b0;
    logic        en_all;
    logic [23:0] fr;
    int          nb;

    always @(negedge clk) begin
        if (rst) begin
            collecting = 1'b0;
        end else begin
            if (req_valid) begin
                req_cyc = cyc;
                pop_check("req", ev(EV_REQ, 24'(req_data)));
            end
            if (timeout) pop_check("timeout", ev(EV_TO, 24'd0));
`ifdef HDX_PARITY_EN
            if (perr) pop_check("perr", ev(EV_PE, 24'd0));
`endif
            if (drive_en && !collecting) begin
                collecting = 1'b1;
                nb = 0;
                fr = '0;
                en_all = 1'b1;
                check("turnaround", 32'(cyc - req_cyc), 32'(TA_CYCLES));
            end
            if (collecting) begin
                fr[nb] = sdio;
                en_all &= drive_en;
                nb++;
                if (nb == FW) begin
                    collecting = 1'b0;
                    pop_check("rsp_frame", ev(EV_FR, fr));
                    check("drive_en_frame", 32'(en_all), 32'd1);
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        tb_en = 1'b1;
        tb_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [DATA_W-1:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
    endtask

    task automatic send_req(input logic [DATA_W-1:0] d);
        send_bits(d);
`ifdef HDX_PARITY_EN
        drive_bit(^d);
`endif
        tb_en = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy && !drive_en) break;
            @(posedge clk);
            #1;
        end
        check("idle_reached", {30'b0, busy, drive_en}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        cycles(2);
        check("rst_drive_en", 32'(drive_en), 32'd0);
        check("rst_sdio_released", 32'(sdio), 32'd1);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_data", 32'(req_data), 32'd0);
        check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cycles(3);

        // response offered on the req_valid cycle
        exp_q.push_back(ev(EV_REQ, 24'h0000A5));
        exp_q.push_back(ev(EV_FR, frame_of(8'h3C)));
        send_req(8'hA5);
        rsp_valid = 1'b1;
        rsp_data  = 8'h3C;
        check("ready_on_req_cycle", 32'(rsp_ready), 32'd1);
        cycles(1);
        rsp_valid = 1'b0;
        check("ready_drops_after_accept", 32'(rsp_ready), 32'd0);
        wait_idle();
        cycles(3);

        // response offered on the last turnaround cycle
        exp_q.push_back(ev(EV_REQ, 24'h000001));
        exp_q.push_back(ev(EV_FR, frame_of(8'hFF)));
        send_req(8'h01);
        cycles(1);
        rsp_valid = 1'b1;
        rsp_data  = 8'hFF;
        check("ready_last_turn", 32'(rsp_ready), 32'd1);
        cycles(1);
        rsp_valid = 1'b0;
        wait_idle();
        cycles(3);

        // no response -> timeout, then a normal request
        exp_q.push_back(ev(EV_REQ, 24'h000055));
        exp_q.push_back(ev(EV_TO, 24'd0));
        send_req(8'h55);
        wait_idle();
        cycles(4);
        check("timeout_no_drive", 32'(drive_en), 32'd0);
        exp_q.push_back(ev(EV_REQ, 24'h000066));
        exp_q.push_back(ev(EV_FR, frame_of(8'h81)));
        send_req(8'h66);
        rsp_valid = 1'b1;
        rsp_data  = 8'h81;
        cycles(1);
        rsp_valid = 1'b0;
        wait_idle();
        cycles(3);

        // reset while transmitting data bit 3
        exp_q.push_back(ev(EV_REQ, 24'h000012));
        send_req(8'h12);
        rsp_valid = 1'b1;
        rsp_data  = 8'hC3;
        cycles(1);
        rsp_valid = 1'b0;
        cycles(5);
        check("tx_bit3_drive_en", 32'(drive_en), 32'd1);
        check("tx_bit3_value", 32'(sdio), 32'd0);
        rst = 1'b1;
        cycles(1);
        check("midrst_drive_en", 32'(drive_en), 32'd0);
        check("midrst_sdio_released", 32'(sdio), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cycles(20);
        check("post_rst_idle", {30'b0, busy, drive_en}, 32'd0);

        // rsp_valid in IDLE is ignored
        rsp_valid = 1'b1;
        rsp_data  = 8'hEE;
        cycles(1);
        check("idle_rsp_ready", 32'(rsp_ready), 32'd0);
        cycles(3);
        check("idle_no_drive", 32'(drive_en), 32'd0);
        rsp_valid = 1'b0;

        // line held low during turnaround is ignored
        exp_q.push_back(ev(EV_REQ, 24'h00005A));
        exp_q.push_back(ev(EV_TO, 24'd0));
        send_req(8'h5A);
        drive_bit(1'b0);
        drive_bit(1'b0);
        tb_en = 1'b0;
        cycles(20);
        check("turn_low_no_frame", {30'b0, busy, drive_en}, 32'd0);

`ifdef HDX_PARITY_EN
        // wrong parity: 0x07 needs parity 1
        exp_q.push_back(ev(EV_PE, 24'd0));
        send_bits(8'h07);
        drive_bit(1'b0);
        tb_en = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 8'h03;
        cycles(1);
        check("perr_no_ready", 32'(rsp_ready), 32'd0);
        rsp_valid = 1'b0;
        cycles(10);
        check("perr_no_drive", {30'b0, busy, drive_en}, 32'd0);
        exp_q.push_back(ev(EV_REQ, 24'h000007));
        exp_q.push_back(ev(EV_FR, frame_of(8'h03)));
        send_req(8'h07);
        rsp_valid = 1'b1;
        rsp_data  = 8'h03;
        cycles(1);
        rsp_valid = 1'b0;
        wait_idle();
        cycles(3);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
